// File: rtl/hazard_fwd_ctrl.sv
// ============================================================================
// Module   : hazard_fwd_ctrl
// Brief    : EX operand forwarding selects and pipeline hold/bubble/flush FSM
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_fwd_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic             ex_MemRd,
    input  logic             ex_RegWr,
    input  logic [4:0]       ex_rd,
    input  logic             mem_MemRd,
    input  logic             mem_RegWr,
    input  logic [4:0]       mem_rd,
    input  logic             dmem_ready,
    input  logic             wb_RegWr,
    input  logic [4:0]       wb_rd,
    input  logic             extra_RegWr,
    input  logic [4:0]       extra_rd,
    input  logic             br_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             idex_bubble,
    output logic             pipe_hold,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        S_RUN      = 2'b00,
        S_LU_STALL = 2'b01,
        S_MEM_WAIT = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic w_load_use, w_mem_wait;
    logic w_pc_hold, w_ifid_hold, w_idex_bubble, w_pipe_hold, w_ifid_flush, w_idex_flush;

    // A load in MEM never supplies EX/MEM forwarding; its data only exists later.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       m_wr, input logic m_rd_mem, input logic [4:0] m_rd,
        input logic       w_wr, input logic [4:0] w_rd,
        input logic       x_wr, input logic [4:0] x_rd
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (m_wr && !m_rd_mem && (m_rd != 5'd0) && (m_rd == rs))
            sel = 2'b01;
        else if (w_wr && (w_rd != 5'd0) && (w_rd == rs))
            sel = 2'b10;
        else if (x_wr && (x_rd != 5'd0) && (x_rd == rs))
            sel = 2'b11;
        return sel;
    endfunction

    always_comb begin
        fwd_a = fwd_sel(ex_rs1, mem_RegWr, mem_MemRd, mem_rd, wb_RegWr, wb_rd,
                        extra_RegWr, extra_rd);
        fwd_b = fwd_sel(ex_rs2, mem_RegWr, mem_MemRd, mem_rd, wb_RegWr, wb_rd,
                        extra_RegWr, extra_rd);
    end

    assign w_load_use = ex_MemRd && ex_RegWr && (ex_rd != 5'd0) &&
                        ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                         (id_use_rs2 && (id_rs2 == ex_rd)));
    assign w_mem_wait = mem_MemRd && !dmem_ready;

    always_comb begin
        state_d       = state_q;
        w_pc_hold     = 1'b0;
        w_ifid_hold   = 1'b0;
        w_idex_bubble = 1'b0;
        w_pipe_hold   = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_flush  = 1'b0;
        case (state_q)
            S_RUN: begin
                if (w_mem_wait) begin
                    w_pipe_hold = 1'b1;
                    w_pc_hold   = 1'b1;
                    w_ifid_hold = 1'b1;
                    state_d     = S_MEM_WAIT;
                end else if (br_flush) begin
                    w_ifid_flush = 1'b1;
                    w_idex_flush = 1'b1;
                end else if (w_load_use) begin
                    w_pc_hold     = 1'b1;
                    w_ifid_hold   = 1'b1;
                    w_idex_bubble = 1'b1;
                    state_d       = S_LU_STALL;
                end
            end
            S_LU_STALL: begin
                state_d = S_RUN;
                if (w_mem_wait) begin
                    w_pipe_hold = 1'b1;
                    w_pc_hold   = 1'b1;
                    w_ifid_hold = 1'b1;
                    state_d     = S_MEM_WAIT;
                end else if (br_flush) begin
                    w_ifid_flush = 1'b1;
                    w_idex_flush = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                // EX is frozen here, so a pending br_flush is taken after the wait.
                if (w_mem_wait) begin
                    w_pipe_hold = 1'b1;
                    w_pc_hold   = 1'b1;
                    w_ifid_hold = 1'b1;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    assign pc_hold     = rst && w_pc_hold;
    assign ifid_hold   = rst && w_ifid_hold;
    assign idex_bubble = rst && w_idex_bubble;
    assign pipe_hold   = rst && w_pipe_hold;
    assign ifid_flush  = rst && w_ifid_flush;
    assign idex_flush  = rst && w_idex_flush;

    assign cnt_d = (pc_hold && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state        = state_q;
    assign stall_cycles = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_fwd_ctrl.sv
// ============================================================================
// Module   : tb_hazard_fwd_ctrl
// Brief    : Directed vectors with a spec-level reference model and literal pins
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_fwd_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd, extra_rd;
    logic       id_use_rs1, id_use_rs2, ex_MemRd, ex_RegWr, mem_MemRd, mem_RegWr;
    logic       dmem_ready, wb_RegWr, extra_RegWr, br_flush;

    logic [1:0]  fwd_a, fwd_b, state, fwd_a4, fwd_b4, state4;
    logic        pc_hold, ifid_hold, idex_bubble, pipe_hold, ifid_flush, idex_flush;
    logic        pc_hold4, ifid_hold4, idex_bubble4, pipe_hold4, ifid_flush4, idex_flush4;
    logic [15:0] stall_cycles;
    logic [3:0]  stall_cycles4;

    hazard_fwd_ctrl dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_MemRd(ex_MemRd), .ex_RegWr(ex_RegWr), .ex_rd(ex_rd),
        .mem_MemRd(mem_MemRd), .mem_RegWr(mem_RegWr), .mem_rd(mem_rd), .dmem_ready(dmem_ready),
        .wb_RegWr(wb_RegWr), .wb_rd(wb_rd), .extra_RegWr(extra_RegWr), .extra_rd(extra_rd),
        .br_flush(br_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_bubble(idex_bubble),
        .pipe_hold(pipe_hold), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .state(state), .stall_cycles(stall_cycles)
    );

    hazard_fwd_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_MemRd(ex_MemRd), .ex_RegWr(ex_RegWr), .ex_rd(ex_rd),
        .mem_MemRd(mem_MemRd), .mem_RegWr(mem_RegWr), .mem_rd(mem_rd), .dmem_ready(dmem_ready),
        .wb_RegWr(wb_RegWr), .wb_rd(wb_rd), .extra_RegWr(extra_RegWr), .extra_rd(extra_rd),
        .br_flush(br_flush), .fwd_a(fwd_a4), .fwd_b(fwd_b4),
        .pc_hold(pc_hold4), .ifid_hold(ifid_hold4), .idex_bubble(idex_bubble4),
        .pipe_hold(pipe_hold4), .ifid_flush(ifid_flush4), .idex_flush(idex_flush4),
        .state(state4), .stall_cycles(stall_cycles4)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 = running, 1 = one-cycle load-use stall, 2 = waiting on memory
    int m_mode = 0, m_c16 = 0, m_c4 = 0;
    int n_mode = 0, n_c16 = 0, n_c4 = 0;

    function automatic int fwd_model(input int rs);
        bit en[3];
        int rd[3];
        en[0] = mem_RegWr && !mem_MemRd; rd[0] = mem_rd;
        en[1] = wb_RegWr;                rd[1] = wb_rd;
        en[2] = extra_RegWr;             rd[2] = extra_rd;
        for (int i = 0; i < 3; i++)
            if (en[i] && rd[i] != 0 && rd[i] == rs) return i + 1;
        return 0;
    endfunction

    always @(negedge clk) begin
        bit lu, mw, e_pipe, e_pc, e_ifid, e_bub, e_fl;
        int nm;
        lu = ex_MemRd && ex_RegWr && ex_rd != 0 &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        mw = mem_MemRd && !dmem_ready;
        e_pipe = 0; e_pc = 0; e_ifid = 0; e_bub = 0; e_fl = 0; nm = 0;
        if (m_mode == 2) begin
            e_pipe = mw; e_pc = mw; e_ifid = mw; nm = mw ? 2 : 0;
        end else if (mw) begin
            e_pipe = 1; e_pc = 1; e_ifid = 1; nm = 2;
        end else if (br_flush) begin
            e_fl = 1;
        end else if (lu && m_mode == 0) begin
            e_pc = 1; e_ifid = 1; e_bub = 1; nm = 1;
        end
        if (!rst) begin
            e_pipe = 0; e_pc = 0; e_ifid = 0; e_bub = 0; e_fl = 0;
        end
        chk("fwd_a", {30'd0, fwd_a}, fwd_model(ex_rs1));
        chk("fwd_b", {30'd0, fwd_b}, fwd_model(ex_rs2));
        chk("holds", {pipe_hold, pc_hold, ifid_hold}, {e_pipe, e_pc, e_ifid});
        chk("bubble", {31'd0, idex_bubble}, {31'd0, e_bub});
        chk("flushes", {ifid_flush, idex_flush}, {e_fl, e_fl});
        chk("state", {30'd0, state}, m_mode);
        chk("stall16", {16'd0, stall_cycles}, m_c16);
        chk("stall4", {28'd0, stall_cycles4}, m_c4);
        chk("w4_match", {state4, pc_hold4, pipe_hold4, ifid_hold4, idex_bubble4, ifid_flush4,
                         idex_flush4, fwd_a4, fwd_b4}, {m_mode[1:0], e_pc, e_pipe, e_ifid, e_bub,
                         e_fl, e_fl, 2'(fwd_model(ex_rs1)), 2'(fwd_model(ex_rs2))});
        n_mode = rst ? nm : 0;
        n_c16  = !rst ? 0 : (e_pc && m_c16 < 65535) ? m_c16 + 1 : m_c16;
        n_c4   = !rst ? 0 : (e_pc && m_c4 < 15) ? m_c4 + 1 : m_c4;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode <= 0; m_c16 <= 0; m_c4 <= 0;
        end else begin
            m_mode <= n_mode; m_c16 <= n_c16; m_c4 <= n_c4;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd, extra_rd} = '0;
        {id_use_rs1, id_use_rs2, ex_MemRd, ex_RegWr, mem_MemRd, mem_RegWr} = '0;
        {wb_RegWr, extra_RegWr, br_flush} = '0;
        dmem_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic set_load_use();
        ex_MemRd = 1; ex_RegWr = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1;
    endtask

    initial begin
        // Reset holds everything quiet even with hazards present; forwarding stays live
        rst = 1'b0;
        clear_inputs();
        mem_MemRd = 1; dmem_ready = 0; br_flush = 1;
        mem_RegWr = 1; mem_rd = 5'd3; ex_rs1 = 5'd3;
        #3;
        chk("rst_outputs", {pipe_hold, pc_hold, ifid_flush, idex_flush, idex_bubble}, 5'b0);
        chk("rst_state", {30'd0, state}, 0);
        chk("rst_fwd", {30'd0, fwd_a}, 32'd0);   // mem_MemRd blocks EX/MEM forwarding
        mem_MemRd = 0;
        #1;
        chk("rst_fwd_live", {30'd0, fwd_a}, 32'd1);
        step();
        chk("rst_stall", {16'd0, stall_cycles}, 32'd0);
        do_reset();

        // Load-use: one-cycle bubble, 00 -> 01 -> 00
        set_load_use();
        #1;
        chk("lu_hold", {pc_hold, ifid_hold, idex_bubble, pipe_hold}, 4'b1110);
        step();
        chk("lu_state1", {30'd0, state}, 32'd1);
        chk("lu_nohold", {pc_hold, idex_bubble}, 2'b00);
        chk("lu_cnt1", {16'd0, stall_cycles}, 32'd1);
        clear_inputs();
        step();
        chk("lu_state0", {30'd0, state}, 32'd0);
        chk("lu_cnt_final", {16'd0, stall_cycles}, 32'd1);

        // Load-use on rs2, rs1 unused; then LU_STALL sees a flush
        id_rs2 = 5'd9; id_use_rs2 = 1; id_rs1 = 5'd9; ex_MemRd = 1; ex_RegWr = 1; ex_rd = 5'd9;
        step();
        br_flush = 1;
        #1;
        chk("lu_flush", {ifid_flush, idex_flush, pc_hold}, 3'b110);
        clear_inputs();
        step();
        // Load-use then mem_wait during LU_STALL
        set_load_use();
        step();
        mem_MemRd = 1; dmem_ready = 0;
        #1;
        chk("lu_memwait", {pipe_hold, pc_hold, idex_bubble}, 3'b110);
        step();
        chk("lu_to_mw", {30'd0, state}, 32'd2);
        clear_inputs();
        step();

        // Forwarding priority
        ex_rs1 = 5'd7; mem_rd = 5'd7; wb_rd = 5'd7; extra_rd = 5'd7;
        mem_RegWr = 1; wb_RegWr = 1; extra_RegWr = 1;
        #1; chk("fwd_p01", {30'd0, fwd_a}, 32'd1);
        mem_RegWr = 0;
        #1; chk("fwd_p10", {30'd0, fwd_a}, 32'd2);
        wb_RegWr = 0;
        #1; chk("fwd_p11", {30'd0, fwd_a}, 32'd3);
        ex_rs1 = 5'd0;
        #1; chk("fwd_p00", {30'd0, fwd_a}, 32'd0);
        step();
        mem_RegWr = 1; mem_rd = 5'd0; wb_RegWr = 1; wb_rd = 5'd0; ex_rs2 = 5'd0; extra_rd = 5'd4;
        #1; chk("fwd_x0", {30'd0, fwd_b}, 32'd0);
        ex_rs2 = 5'd4;
        #1; chk("fwd_b_extra", {30'd0, fwd_b}, 32'd3);
        step();
        clear_inputs();

        // Memory wait for three cycles
        do_reset();
        mem_MemRd = 1; dmem_ready = 0;
        #1; chk("mw_c1", {30'd0, state, pipe_hold}, {29'd0, 2'b00, 1'b1});
        step(); chk("mw_c2", {state, pipe_hold}, {2'b10, 1'b1});
        step(); chk("mw_c3", {state, pipe_hold}, {2'b10, 1'b1});
        step(); dmem_ready = 1;
        #1; chk("mw_ready", {state, pipe_hold, pc_hold}, {2'b10, 2'b00});
        step(); mem_MemRd = 0;
        #1; chk("mw_done", {30'd0, state}, 32'd0);
        chk("mw_cnt", {16'd0, stall_cycles}, 32'd3);

        // Simultaneous mem_wait, br_flush, load_use
        do_reset();
        mem_MemRd = 1; dmem_ready = 0; br_flush = 1; set_load_use();
        #1; chk("pri_holds", {pipe_hold, pc_hold, ifid_flush, idex_flush, idex_bubble}, 5'b11000);
        step(); chk("pri_mw_noflush", {ifid_flush, idex_flush}, 2'b00);
        dmem_ready = 1;
        #1; chk("pri_ready", {pipe_hold, ifid_flush}, 2'b00);
        step(); mem_MemRd = 0;
        #1; chk("pri_flush", {ifid_flush, idex_flush, idex_bubble, pc_hold}, 4'b1100);
        step();

        // Saturation: 20 hold cycles
        do_reset();
        mem_MemRd = 1; dmem_ready = 0;
        repeat (20) step();
        chk("sat4", {28'd0, stall_cycles4}, 32'd15);
        chk("sat16", {16'd0, stall_cycles}, 32'd20);

        // Async reset between edges while in MEM_WAIT
        #2;
        rst = 1'b0;
        #1;
        chk("arst_state", {30'd0, state}, 32'd0);
        chk("arst_cnt", {16'd0, stall_cycles, 12'd0, stall_cycles4}, 32'd0);
        chk("arst_hold", {pipe_hold, pc_hold}, 2'b00);
        step();
        clear_inputs();
        rst = 1'b1;
        #1; chk("arst_resume", {30'd0, state, pc_hold}, 32'd0);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
